// File: rtl/nanci_phase_scheduler.sv
// Per-node compute/communicate round sequencer between one application and the Nanci network port.
// Optional response watchdog enabled by defining NANCI_SCHED_TIMEOUT_EN.
module nanci_phase_scheduler #(
   parameter int unsigned N          = 1024,
   parameter int unsigned I          = 0,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROUNDS     = 16,
   parameter int unsigned TIMEOUT    = 1024,
   localparam int unsigned ADDR_WIDTH = (N == 1024) ? 10 : (N == 256) ? 8 :
                                        (N == 64)   ? 6  : (N == 16)  ? 4 : 2,
   localparam int unsigned WIDTH      = ADDR_WIDTH + DATA_WIDTH,
   localparam int unsigned RW         = $clog2(ROUNDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [13:0]      i_compute_cycles,
   output logic             o_runnable,
   input  logic [WIDTH:0]   i_app_request,
   output logic [WIDTH:0]   o_nanci_result,
   output logic             o_net_req_valid,
   input  logic             i_net_req_ready,
   output logic [WIDTH:0]   o_net_req_data,
   input  logic             i_net_resp_valid,
   input  logic [WIDTH:0]   i_net_resp_data,
   output logic             o_busy,
   output logic             o_done,
   output logic [RW-1:0]    o_round,
   output logic             o_error
);

   if (ROUNDS < 1) begin : g_bad_rounds
      $error("ROUNDS must be at least 1");
   end
   if (I >= N) begin : g_bad_index
      $error("node index I must be below N");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

   typedef enum logic [2:0] {
      StIdle,
      StCompute,
      StRun,
      StCapture,
      StIssue,
      StWaitResp
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [13:0]     r_cnt, w_cnt_nxt;
   logic [WIDTH:0]  r_req, w_req_nxt;
   logic [WIDTH:0]  r_res, w_res_nxt;
   logic [RW-1:0]   r_round, w_round_nxt;
   logic [RW-1:0]   w_round_inc;
   logic            r_done, w_done_nxt;
   logic [13:0]     w_load;

`ifdef NANCI_SCHED_TIMEOUT_EN
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0]  r_wd, w_wd_nxt;
   logic            r_error, w_error_nxt;
`endif

   // A zero latency still needs one COMPUTE cycle so RUN is never skipped.
   assign w_load      = (i_compute_cycles == 14'd0) ? 14'd1 : i_compute_cycles;
   assign w_round_inc = r_round + RW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = r_req;
      w_res_nxt   = r_res;
      w_round_nxt = r_round;
      w_done_nxt  = 1'b0;
`ifdef NANCI_SCHED_TIMEOUT_EN
      w_wd_nxt    = r_wd;
      w_error_nxt = r_error;
`endif
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_round_nxt = '0;
               w_cnt_nxt   = w_load;
               w_state_nxt = StCompute;
`ifdef NANCI_SCHED_TIMEOUT_EN
               w_error_nxt = 1'b0;
`endif
            end
         end
         StCompute: begin
            w_cnt_nxt = r_cnt - 14'd1;
            if (r_cnt <= 14'd1) begin
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            w_state_nxt = StCapture;
         end
         StCapture: begin
            w_req_nxt   = i_app_request;
            w_state_nxt = StIssue;
         end
         StIssue: begin
            if (i_net_req_ready) begin
               w_state_nxt = StWaitResp;
`ifdef NANCI_SCHED_TIMEOUT_EN
               w_wd_nxt    = '0;
`endif
            end
         end
         StWaitResp: begin
            if (i_net_resp_valid) begin
               w_res_nxt   = i_net_resp_data;
               w_round_nxt = w_round_inc;
               if (w_round_inc == RW'(ROUNDS)) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = StIdle;
               end else begin
                  w_cnt_nxt   = w_load;
                  w_state_nxt = StCompute;
               end
            end
`ifdef NANCI_SCHED_TIMEOUT_EN
            else if (r_wd == WDW'(TIMEOUT - 1)) begin
               w_error_nxt = 1'b1;
               w_state_nxt = StIdle;
            end else begin
               w_wd_nxt = r_wd + WDW'(1);
            end
`endif
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_req   <= '0;
         r_res   <= '0;
         r_round <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req   <= w_req_nxt;
         r_res   <= w_res_nxt;
         r_round <= w_round_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef NANCI_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd    <= '0;
         r_error <= 1'b0;
      end else begin
         r_wd    <= w_wd_nxt;
         r_error <= w_error_nxt;
      end
   end

   assign o_error = r_error;
`else
   assign o_error = 1'b0;
`endif

   // Handshake outputs decode straight from state so reset drops valid without a clock.
   assign o_runnable      = (r_state == StRun);
   assign o_net_req_valid = (r_state == StIssue);
   assign o_busy          = (r_state != StIdle);
   assign o_net_req_data  = r_req;
   assign o_nanci_result  = r_res;
   assign o_round         = r_round;
   assign o_done          = r_done;

endmodule

// File: doc/nanci_phase_scheduler.md
# nanci_phase_scheduler

Per-node sequencer that drives one `application` instance through repeated compute/communicate rounds. It counts out the application's reported compute latency, pulses `runnable`, captures the resulting `app_request`, and forwards it to the Nanci network over a valid/ready handshake. It then waits for the network response, returns it on `nanci_result`, and repeats for `ROUNDS` rounds. It sits between the user application and the node's network port.

## Interface
- `N`, 1024: node count; sets `ADDR_WIDTH` (1024→10, 256→8, 64→6, 16→4, else 2).
- `I`, 0: this node's index (informational; not used in logic).
- `DATA_WIDTH`, 32: payload width.
- `ROUNDS`, 16: rounds per run, ≥1.
- `TIMEOUT`, 1024: response watchdog limit in cycles; used only with `NANCI_SCHED_TIMEOUT_EN`.
- Derived: `WIDTH = ADDR_WIDTH + DATA_WIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `compute_cycles` in 14: application compute latency.
- `runnable` out 1: one-cycle pulse to the application.
- `app_request` in WIDTH+1: bit WIDTH = write flag, [WIDTH-1:DATA_WIDTH] = address, [DATA_WIDTH-1:0] = data.
- `nanci_result` out WIDTH+1: last response, registered.
- `net_req_valid` out 1, `net_req_ready` in 1, `net_req_data` out WIDTH+1: request channel.
- `net_resp_valid` in 1, `net_resp_data` in WIDTH+1: response channel, no backpressure.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when the last round completes.
- `round` out $clog2(ROUNDS+1): rounds completed in the current run.
- `error` out 1: sticky watchdog flag.

## Operation
- States: IDLE, COMPUTE, RUN, CAPTURE, ISSUE, WAIT_RESP.
- IDLE: when `start`=1, clear `round` and `error`, load counter with max(`compute_cycles`,1), go to COMPUTE.
- COMPUTE: decrement counter each cycle; at counter=1 go to RUN. `compute_cycles` is sampled only when the counter loads.
- RUN: `runnable`=1 for exactly this cycle; go to CAPTURE.
- CAPTURE: register `app_request` into `net_req_data` at the cycle's end edge; go to ISSUE.
- ISSUE: `net_req_valid`=1 with `net_req_data` held stable. On `net_req_valid & net_req_ready` go to WAIT_RESP.
- WAIT_RESP: on `net_resp_valid`, latch `net_resp_data` into `nanci_result` and increment `round`.
  - If the new `round` = ROUNDS: pulse `done`, go to IDLE.
  - Otherwise reload the counter from `compute_cycles` and go to COMPUTE.
- Every request, read or write, receives exactly one response.
- `net_resp_valid` outside WAIT_RESP is ignored and dropped.
- `start` while busy is ignored.
- `compute_cycles`=0 is treated as 1.

## Timing
- Reset values (async, while `rst_n`=0): state IDLE; `runnable`, `net_req_valid`, `busy`, `done`, `error` = 0; `round`, counter, `net_req_data`, `nanci_result` = 0.
- With `start` sampled at edge 0 and compute latency C: COMPUTE occupies cycles 1..C, `runnable` is high in cycle C+1, CAPTURE is C+2, and `net_req_valid` first rises in cycle C+3.
- `net_req_valid` never deasserts before the handshake; data is unchanged while valid.
- With ready held high, a round takes C+3+R cycles, where R ≥ 1 is the response wait.
- `done` is high in the cycle after the final response edge; `busy` is 0 in that same cycle.
- Reset mid-round discards the in-flight request. `net_req_valid` drops immediately and asynchronously.

## Configuration
- `NANCI_SCHED_TIMEOUT_EN` defined: the watchdog counts WAIT_RESP cycles. On reaching `TIMEOUT` without a response:
  - set `error`=1 (sticky until the next accepted `start` or reset);
  - go to IDLE without pulsing `done`, leaving `round` unchanged.
- `NANCI_SCHED_TIMEOUT_EN` not defined: no watchdog logic; `error` is tied to 0 and WAIT_RESP waits indefinitely.

## Test plan
- Basic round: ROUNDS=1, C=5, ready=1, response 2 cycles after handshake, with value {1,10'd1023,32'd0} → `runnable` in cycle 6, `net_req_valid` in cycle 8, `nanci_result`={1,1023,0}, `done` one cycle, `round`=1.
- Backpressure: hold `net_req_ready`=0 for 7 cycles → `net_req_valid` stays 1 with stable data for 8 cycles; one handshake; exactly one request counted.
- Zero compute: `compute_cycles`=0 → `runnable` in cycle 2 after `start`.
- Multi-round: ROUNDS=4 → four `runnable` pulses, `round` steps 1..4, single `done`, `start` during the run ignored.
- Stray response: `net_resp_valid` pulsed during COMPUTE → `nanci_result` and `round` unchanged.
- Timeout (macro defined, TIMEOUT=16): no response → `error`=1 at the 16th WAIT_RESP cycle, state IDLE, `done`=0. Without the macro the same stimulus leaves `busy`=1 indefinitely and `error`=0.
